led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
- Controller that sequences the LED pattern shift register.
- Generates the one-cycle advance strobe (o_valid) at a switch-selected rate.
- Holds the pattern direction (o_reverse), toggled by a debounced push button.
- Provides run/pause/single-step control from switches and a second button.
- Sits between the board switches/buttons and the LED shift-register datapath; its outputs drive that block's i_valid and i_reverse directly.

Parameters:
- NB_COUNTER, 32: width of the rate counter.
- NB_DEBOUNCE, 20: width of each debounce counter; a button level must be stable for 2**NB_DEBOUNCE cycles to be accepted.
- LIMIT0, 2**22-1: rate counter terminal value, rate select 0 (fastest).
- LIMIT1, 2**23-1: terminal value, rate select 1.
- LIMIT2, 2**24-1: terminal value, rate select 2.
- LIMIT3, 2**25-1: terminal value, rate select 3 (slowest).

Ports:
- clock, input, 1: system clock; all state on rising edge.
- i_reset, input, 1: reset, asynchronous, active-high.
- i_sw, input, 4: [0] enable, [2:1] rate select, [3] hold (pause).
- i_btn_dir, input, 1: raw direction button, asynchronous to clock.
- i_btn_step, input, 1: raw single-step button, asynchronous to clock.
- o_valid, input-facing output, 1: one-cycle advance strobe, registered.
- o_reverse, output, 1: pattern direction, registered.
- o_state, output, 2: current FSM state, for debug LEDs.

Behaviour:
- Reset (asynchronous, active-high, immediate): o_valid=0, o_reverse=0, o_state=ST_IDLE, rate counter=0, sync flops=0, debounced levels=0, debounce counters=0.
- Button conditioning, each button independently:
  - 2-flop synchronizer feeds the debounce stage.
  - Debounce counter increments while the synced level differs from the debounced level; it clears to 0 when they are equal.
  - When the counter is all-ones and the mismatch persists, the debounced level takes the synced level and the counter clears.
  - A rising edge of the debounced level yields a one-cycle registered pulse (dir_pulse or step_pulse).
  - Release is debounced the same way and produces no pulse.
- Direction:
  - dir_pulse toggles o_reverse in every state, including IDLE.
  - If a toggle lands on the same edge that sets o_valid, both register together; the datapath sees the new direction with that strobe.
- FSM states (encodings in package): ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10. Encoding 2'b11 is illegal and recovers to ST_IDLE on the next edge.
  - Any state -> ST_IDLE when i_sw[0]=0. This has highest priority.
  - ST_IDLE -> ST_RUN when i_sw[0]=1 and i_sw[3]=0.
  - ST_IDLE -> ST_PAUSE when i_sw[0]=1 and i_sw[3]=1.
  - ST_RUN -> ST_PAUSE when i_sw[3]=1.
  - ST_PAUSE -> ST_RUN when i_sw[3]=0.
- Rate counter:
  - In ST_RUN it increments each cycle.
  - When counter >= LIMIT[i_sw[2:1]] at an edge: counter <= 0 and o_valid <= 1 for exactly one cycle.
  - Strobe period is therefore LIMIT+1 cycles.
  - The counter is held at 0 in ST_IDLE and ST_PAUSE, so re-entering ST_RUN restarts a full period.
  - Rate change mid-count: the new limit applies immediately. If the count already exceeds the new limit, the strobe fires on the next edge.
- Step: step_pulse in ST_PAUSE makes o_valid=1 for one cycle on the following edge. step_pulse is ignored in ST_IDLE and ST_RUN.
- o_valid is never asserted in ST_IDLE, nor on the edge that enters ST_IDLE.
- Switches are static-ish and are used without synchronization. Glitches only cost one cycle of state.

Decomposition:
- Package led_ctrl_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE;
  - switch bit indices SW_EN=0, SW_RATE_LO=1, SW_RATE_HI=2, SW_HOLD=3;
  - state width NB_STATE=2.
- Sub-module btn_debounce (parameter NB_DEBOUNCE; ports clock, i_reset, i_btn, o_level, o_rise) contains synchronizer, debounce counter and edge pulse. It is instantiated twice.
- Top level holds the FSM, rate counter with limit mux, and direction register.

Test Plan:
All tests use NB_COUNTER=8, NB_DEBOUNCE=2, LIMIT0=3, LIMIT1=7, LIMIT2=15, LIMIT3=31.
- Reset/idle: assert i_reset mid-cycle -> all outputs 0 immediately; with i_sw=4'b0000 for 100 cycles -> o_valid never 1, o_state=00.
- Run rate: i_sw=4'b0001 -> o_state=01, then o_valid pulses every 4 cycles. Switch to i_sw=4'b0101 (rate 2) -> period 16; switch from rate 3 at count 20 to rate 0 -> strobe on next edge, then period 4.
- Direction button: hold i_btn_dir=1 for 10 cycles -> o_reverse toggles 0->1 exactly once. Bounce 1/0 every 2 cycles for 20 cycles -> no toggle. Release and press again -> o_reverse back to 0.
- Pause/step: in RUN set i_sw[3]=1 -> o_state=10, no strobes for 50 cycles. Press step twice, with debounced presses -> exactly 2 single-cycle o_valid pulses. Clear i_sw[3] -> first strobe 4 cycles after re-entering RUN.
- Simultaneous events: dir_pulse on the same edge as the rate strobe -> o_valid=1 and the new o_reverse are both visible in the same cycle. Clear i_sw[0] on the terminal-count cycle -> no strobe, o_state=00.
- Reset mid-debounce/mid-count: assert i_reset with count=2 and the button half-debounced -> after release, no spurious dir toggle and the count restarts from 0.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and switch bit positions for the LED sequencer controller.
package led_ctrl_pkg;

  localparam int unsigned NB_STATE = 2;
  localparam int unsigned NB_SW    = 4;

  localparam int unsigned SW_EN      = 0;
  localparam int unsigned SW_RATE_LO = 1;
  localparam int unsigned SW_RATE_HI = 2;
  localparam int unsigned SW_HOLD    = 3;

  // 2'b11 is unused; the FSM steers it back to ST_IDLE
  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Board-side controls in, datapath-side strobe/direction out.
interface led_seq_ctrl_if;
  import led_ctrl_pkg::*;

  logic [NB_SW-1:0]    i_sw;
  logic                i_btn_dir;
  logic                i_btn_step;
  logic                o_valid;
  logic                o_reverse;
  logic [NB_STATE-1:0] o_state;

  // master drives the switches/buttons and observes the controller
  modport master (
    output i_sw, i_btn_dir, i_btn_step,
    input  o_valid, o_reverse, o_state
  );

  // slave is the controller itself
  modport slave (
    input  i_sw, i_btn_dir, i_btn_step,
    output o_valid, o_reverse, o_state
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchronizes a raw button, debounces it, and pulses once per accepted press.
module btn_debounce #(
  parameter int unsigned NB_DEBOUNCE = 20
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam logic [NB_DEBOUNCE-1:0] CNT_MAX = '1;

  logic                   sync_q1;
  logic                   sync_q2;
  logic [NB_DEBOUNCE-1:0] cnt_q;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has disagreed for 2**NB_DEBOUNCE cycles
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q   <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      if (sync_q2 != o_level) begin
        if (cnt_q == CNT_MAX) begin
          o_level <= sync_q2;
          cnt_q   <= '0;
          o_rise  <= sync_q2;
        end else begin
          cnt_q <= cnt_q + NB_DEBOUNCE'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Sequencing controller: run/pause FSM, rate strobe generator and direction toggle.
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NB_COUNTER  = 32,
  parameter int unsigned NB_DEBOUNCE = 20,
  parameter int unsigned LIMIT0      = 32'd4194303,
  parameter int unsigned LIMIT1      = 32'd8388607,
  parameter int unsigned LIMIT2      = 32'd16777215,
  parameter int unsigned LIMIT3      = 32'd33554431
) (
  input  logic          clock,
  input  logic          i_reset,
  led_seq_ctrl_if.slave bus
);

  localparam logic [NB_COUNTER-1:0] LIM0_C = NB_COUNTER'(LIMIT0);
  localparam logic [NB_COUNTER-1:0] LIM1_C = NB_COUNTER'(LIMIT1);
  localparam logic [NB_COUNTER-1:0] LIM2_C = NB_COUNTER'(LIMIT2);
  localparam logic [NB_COUNTER-1:0] LIM3_C = NB_COUNTER'(LIMIT3);

  state_t                  state_q;
  state_t                  state_d;
  logic [NB_COUNTER-1:0]   count_q;
  logic [NB_COUNTER-1:0]   count_d;
  logic [NB_COUNTER-1:0]   limit_c;
  logic                    valid_q;
  logic                    valid_d;
  logic                    reverse_q;
  logic                    reverse_d;
  logic                    dir_pulse;
  logic                    step_pulse;
  logic                    dir_level;
  logic                    step_level;
  logic                    unused_levels;
  logic                    sw_en;
  logic                    sw_hold;
  logic [1:0]              sw_rate;

  assign sw_en   = bus.i_sw[SW_EN];
  assign sw_hold = bus.i_sw[SW_HOLD];
  assign sw_rate = bus.i_sw[SW_RATE_HI:SW_RATE_LO];

  btn_debounce #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_dir_btn (
    .clock   (clock),
    .i_reset (i_reset),
    .i_btn   (bus.i_btn_dir),
    .o_level (dir_level),
    .o_rise  (dir_pulse)
  );

  btn_debounce #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_step_btn (
    .clock   (clock),
    .i_reset (i_reset),
    .i_btn   (bus.i_btn_step),
    .o_level (step_level),
    .o_rise  (step_pulse)
  );

  // Debounced levels are only needed for the edge pulses
  assign unused_levels = &{1'b0, dir_level, step_level};

  // Terminal count selected by the rate switches; takes effect immediately
  always_comb begin
    limit_c = LIM3_C;
    case (sw_rate)
      2'd0:    limit_c = LIM0_C;
      2'd1:    limit_c = LIM1_C;
      2'd2:    limit_c = LIM2_C;
      default: limit_c = LIM3_C;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: disable wins over everything, hold picks pause vs run
  always_comb begin
    state_d = state_q;
    if (!sw_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = sw_hold ? ST_PAUSE : ST_RUN;
        ST_RUN:   if (sw_hold)  state_d = ST_PAUSE;
        ST_PAUSE: if (!sw_hold) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output/counter next values; strobes are suppressed on the way into idle
  always_comb begin
    count_d   = '0;
    valid_d   = 1'b0;
    reverse_d = reverse_q ^ dir_pulse;
    case (state_q)
      ST_RUN: begin
        if (count_q >= limit_c) begin
          count_d = '0;
          valid_d = sw_en;
        end else begin
          count_d = count_q + NB_COUNTER'(1);
        end
      end
      ST_PAUSE: valid_d = sw_en & step_pulse;
      default:  count_d = '0;
    endcase
  end

  // Registered outputs and rate counter
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      count_q   <= '0;
      valid_q   <= 1'b0;
      reverse_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      valid_q   <= valid_d;
      reverse_q <= reverse_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_reverse = reverse_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with a behavioural reference model and directed pins.
module tb_led_seq_ctrl;

  localparam int DEB_CYCLES = 4;  // 2**NB_DEBOUNCE with NB_DEBOUNCE=2

  int   lims [4] = '{3, 7, 15, 31};
  logic clock    = 1'b0;
  logic i_reset  = 1'b0;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(
    .NB_COUNTER (8),
    .NB_DEBOUNCE(2),
    .LIMIT0     (3),
    .LIMIT1     (7),
    .LIMIT2     (15),
    .LIMIT3     (31)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=pause; buttons index 0=dir 1=step
  int m_mode;
  int m_elapsed;
  bit m_valid;
  bit m_rev;
  bit b_s1 [2];
  bit b_s2 [2];
  bit b_lvl [2];
  bit b_pulse [2];
  int b_run [2];

  always @(posedge clock or posedge i_reset) begin : model_p
    bit btn [2];
    bit en;
    bit hold;
    int lim;
    bit nvalid;
    if (i_reset) begin
      m_mode = 0; m_elapsed = 0; m_valid = 0; m_rev = 0;
      for (int i = 0; i < 2; i++) begin
        b_s1[i] = 0; b_s2[i] = 0; b_lvl[i] = 0; b_pulse[i] = 0; b_run[i] = 0;
      end
    end else begin
      btn[0] = bus.i_btn_dir;
      btn[1] = bus.i_btn_step;
      en     = bus.i_sw[0];
      hold   = bus.i_sw[3];
      lim    = lims[bus.i_sw[2:1]];
      // a strobe needs a finished period in run, or a step press in pause
      nvalid = en && ((m_mode == 1 && m_elapsed >= lim) || (m_mode == 2 && b_pulse[1]));
      if (m_mode != 1 || m_elapsed >= lim) m_elapsed = 0;
      else m_elapsed = m_elapsed + 1;
      if (b_pulse[0]) m_rev = !m_rev;
      m_mode  = !en ? 0 : (hold ? 2 : 1);
      m_valid = nvalid;
      for (int i = 0; i < 2; i++) begin
        b_pulse[i] = 0;
        if (b_s2[i] != b_lvl[i]) begin
          b_run[i] = b_run[i] + 1;
          if (b_run[i] == DEB_CYCLES) begin
            b_lvl[i]   = b_s2[i];
            b_run[i]   = 0;
            b_pulse[i] = b_s2[i];
          end
        end else begin
          b_run[i] = 0;
        end
        b_s2[i] = b_s1[i];
        b_s1[i] = btn[i];
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc_o_valid",   32'(bus.o_valid),   32'(m_valid));
      chk("cyc_o_reverse", 32'(bus.o_reverse), 32'(m_rev));
      chk("cyc_o_state",   32'(bus.o_state),   32'(m_mode));
    end
  end

  // Event counters sampled just after each active edge
  int valid_cnt   = 0;
  int rev_toggles = 0;
  bit prev_rev    = 1'b0;
  always @(posedge clock) begin
    #1;
    if (bus.o_valid === 1'b1) valid_cnt++;
    if (bus.o_reverse !== prev_rev) rev_toggles++;
    prev_rev = bus.o_reverse;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Negedges until o_valid is seen; -1 if the bound expires
  task automatic wait_valid(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clock);
      if (bus.o_valid === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  int n;
  int v0;
  int t0;
  bit rev0;

  initial begin
    bus.i_sw       = 4'b0000;
    bus.i_btn_dir  = 1'b0;
    bus.i_btn_step = 1'b0;
    #2 i_reset = 1'b1;
    @(negedge clock);
    cmp_en = 1'b1;
    chk("reset_valid",   32'(bus.o_valid),   0);
    chk("reset_reverse", 32'(bus.o_reverse), 0);
    chk("reset_state",   32'(bus.o_state),   0);
    tick(2);
    i_reset = 1'b0;

    // Idle with everything off
    v0 = valid_cnt;
    tick(100);
    chk("idle_no_strobe", 32'(valid_cnt - v0), 0);
    chk("idle_state", 32'(bus.o_state), 0);

    // Run at rate 0
    bus.i_sw = 4'b0001;
    tick(1);
    chk("run_state", 32'(bus.o_state), 1);
    wait_valid(20, n); chk("first_strobe_r0", 32'(n), 4);
    wait_valid(20, n); chk("period_r0_a", 32'(n), 4);
    wait_valid(20, n); chk("period_r0_b", 32'(n), 4);

    // Rate 2
    bus.i_sw = 4'b0101;
    wait_valid(40, n); chk("period_r2_a", 32'(n), 16);
    wait_valid(40, n); chk("period_r2_b", 32'(n), 16);

    // Rate 3 up to count 20, then drop to rate 0
    bus.i_sw = 4'b0111;
    tick(20);
    bus.i_sw = 4'b0001;
    tick(1);
    chk("rate_drop_strobe", 32'(bus.o_valid), 1);
    wait_valid(20, n); chk("rate_drop_period", 32'(n), 4);

    // Direction: clean press toggles once
    t0 = rev_toggles;
    bus.i_btn_dir = 1'b1; tick(10);
    bus.i_btn_dir = 1'b0; tick(10);
    chk("dir_one_toggle", 32'(rev_toggles - t0), 1);
    chk("dir_after_press", 32'(bus.o_reverse), 1);

    // Bouncing button never settles long enough
    t0 = rev_toggles;
    for (int i = 0; i < 10; i++) begin
      bus.i_btn_dir = ~bus.i_btn_dir;
      tick(2);
    end
    tick(10);
    chk("bounce_no_toggle", 32'(rev_toggles - t0), 0);

    bus.i_btn_dir = 1'b1; tick(10);
    bus.i_btn_dir = 1'b0; tick(10);
    chk("dir_back", 32'(bus.o_reverse), 0);

    // Pause and single-step
    bus.i_sw = 4'b1001;
    tick(1);
    chk("pause_state", 32'(bus.o_state), 2);
    v0 = valid_cnt;
    tick(50);
    chk("pause_no_strobe", 32'(valid_cnt - v0), 0);
    v0 = valid_cnt;
    repeat (2) begin
      bus.i_btn_step = 1'b1; tick(10);
      bus.i_btn_step = 1'b0; tick(10);
    end
    chk("two_steps", 32'(valid_cnt - v0), 2);
    bus.i_sw = 4'b0001;
    wait_valid(20, n); chk("resume_first_strobe", 32'(n), 5);

    // Direction change landing on the strobe edge
    tick(1);
    bus.i_btn_dir = 1'b1;
    rev0 = bus.o_reverse;
    wait_valid(20, n); chk("pre_coincide_gap", 32'(n), 3);
    chk("pre_coincide_rev", 32'(bus.o_reverse), 32'(rev0));
    wait_valid(20, n); chk("coincide_gap", 32'(n), 4);
    chk("coincide_rev", 32'(bus.o_reverse), 32'(!rev0));
    bus.i_btn_dir = 1'b0;
    tick(10);

    // Disable on the terminal-count cycle
    wait_valid(20, n);
    tick(3);
    bus.i_sw = 4'b0000;
    tick(1);
    chk("disable_no_strobe", 32'(bus.o_valid), 0);
    chk("disable_state", 32'(bus.o_state), 0);

    // Reset in the middle of a count and a debounce
    bus.i_sw = 4'b0001;
    bus.i_btn_dir = 1'b1;
    tick(3);
    #1 i_reset = 1'b1;
    #1;
    chk("midreset_valid",   32'(bus.o_valid),   0);
    chk("midreset_reverse", 32'(bus.o_reverse), 0);
    chk("midreset_state",   32'(bus.o_state),   0);
    bus.i_btn_dir = 1'b0;
    @(negedge clock);
    i_reset = 1'b0;
    t0 = rev_toggles;
    wait_valid(20, n); chk("post_reset_first_strobe", 32'(n), 5);
    tick(10);
    chk("post_reset_no_toggle", 32'(rev_toggles - t0), 0);

    // Randomised stress checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      #1;
      i_reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 24) == 0) bus.i_sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) bus.i_btn_dir = ~bus.i_btn_dir;
      if ($urandom_range(0, 5) == 0) bus.i_btn_step = ~bus.i_btn_step;
    end
    @(negedge clock);
    #1 i_reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
